mem_line_sequencer: RTL

- Cache-side initiator for the 128-bit slow-memory line interface (read/write/addr[31:4]/wdata/rdata/ready).
- Takes one miss transaction from the L1/L2 cache controller: optional dirty-victim write-back, then optional line refill.
- Drives the memory handshake and returns the fill line, or an error on timeout.
- Sits between the cache controller and the slow memory, replacing ad-hoc handshake logic inside each cache.

---
 rtl/mem_line_sequencer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/mem_line_sequencer.sv
// Cache-side initiator for the line-wide slow-memory interface: runs an optional
// dirty-line write-back, then an optional refill, with a per-phase timeout.
module mem_line_sequencer #(
    parameter int ADDR_W  = 28,
    parameter int LINE_W  = 128,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wb,
    input  logic [ADDR_W-1:0] req_wb_addr,
    input  logic [LINE_W-1:0] req_wb_data,
    input  logic              req_fill,
    input  logic [ADDR_W-1:0] req_fill_addr,
    output logic              resp_valid,
    output logic [LINE_W-1:0] resp_data,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [2:0] {IDLE, WB, GAP, FILL, DONE} state_t;

    state_t            state_q;
    logic              fill_pend_q;
    logic [ADDR_W-1:0] fill_addr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [LINE_W-1:0] mem_wdata_q;
    logic              resp_valid_q;
    logic              resp_err_q;
    logic [LINE_W-1:0] resp_data_q;

    logic [CNT_W-1:0]  cnt_d;
    logic              timeout_d;

    // The wait counter aborts on the edge where it would reach TIMEOUT; a
    // mem_ready on that same edge still wins because it is tested first.
    assign cnt_d     = cnt_q + CNT_W'(1);
    assign timeout_d = (cnt_d == CNT_W'(TIMEOUT));

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_data  = resp_data_q;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            fill_pend_q  <= 1'b0;
            fill_addr_q  <= '0;
            cnt_q        <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        fill_pend_q <= req_fill;
                        fill_addr_q <= req_fill_addr;
                        cnt_q       <= '0;
                        if (req_wb) begin
                            state_q     <= WB;
                            mem_write_q <= 1'b1;
                            mem_addr_q  <= req_wb_addr;
                            mem_wdata_q <= req_wb_data;
                        end else if (req_fill) begin
                            state_q    <= FILL;
                            mem_read_q <= 1'b1;
                            mem_addr_q <= req_fill_addr;
                        end else begin
                            state_q      <= DONE;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b0;
                        end
                    end
                end
                WB: begin
                    if (mem_ready) begin
                        mem_write_q <= 1'b0;
                        if (fill_pend_q) begin
                            state_q <= GAP;
                        end else begin
                            state_q      <= DONE;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b0;
                        end
                    end else if (timeout_d) begin
                        // Abandon the write and any pending refill.
                        mem_write_q  <= 1'b0;
                        state_q      <= DONE;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        resp_data_q  <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                GAP: begin
                    state_q    <= FILL;
                    mem_read_q <= 1'b1;
                    mem_addr_q <= fill_addr_q;
                    cnt_q      <= '0;
                end
                FILL: begin
                    if (mem_ready) begin
                        mem_read_q   <= 1'b0;
                        resp_data_q  <= mem_rdata;
                        state_q      <= DONE;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                    end else if (timeout_d) begin
                        mem_read_q   <= 1'b0;
                        state_q      <= DONE;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        resp_data_q  <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                DONE: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
